parity_pop_scheduler: RTL and testbench
=======================================

# parity_pop_scheduler

Controller between a FIFO pop port and NUM_RX receivers sharing it. Checks the parity bit of each word the FIFO offers. Silently consumes and counts bad-parity words. Buffers each good word in a single output register and hands it to one receiver chosen by round-robin, with a hold timeout that re-assigns a word whose owner stalls.

## Interface
- DATA_WIDTH, 8: payload bits; FIFO word is DATA_WIDTH+1 bits including parity.
- NUM_RX, 4: number of receivers, 2..16.
- EVEN_ODD, 0: required parity-bit value for a good word, EVEN(0) or ODD(1).
- SELECT_PARITY_BIT, 0: parity bit position, MSB(1) or LSB(0).
- HOLD_TIMEOUT, 16: HOLD cycles before re-assignment; 0 disables the timeout.
- ERR_CNT_WIDTH, 8: width of the error counter.
- clk  in  1  single clock, all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- data_in  in  DATA_WIDTH+1  FIFO head word.
- pop_valid_fifo  in  1  FIFO head word valid.
- pop_grant_fifo  out  1  pop accepted; a transfer occurs when pop_valid_fifo and pop_grant_fifo are both high.
- req_receiver  in  NUM_RX  receiver i wants a word.
- rx_enable  in  NUM_RX  configuration mask; a disabled receiver is never selected.
- pop_valid_receiver  out  NUM_RX  one-hot; word offered to the owner.
- pop_grant_receiver  in  NUM_RX  receiver ready; the owner transfers when its valid and grant are both high.
- data_out  out  DATA_WIDTH  buffered payload with the parity bit stripped.
- owner  out  $clog2(NUM_RX)  index of the current owner.
- parity_err  out  1  one-cycle pulse after a dropped word.
- parity_err_count  out  ERR_CNT_WIDTH  saturating count of dropped words.

## Operation
- Parity bit: data_in[DATA_WIDTH] if SELECT_PARITY_BIT, else data_in[0].
- Good word: parity bit == EVEN_ODD.
- Payload: data_in[DATA_WIDTH-1:0] if SELECT_PARITY_BIT, else data_in[DATA_WIDTH:1].
- Eligible set: req_receiver & rx_enable.
- Round-robin pick: first set bit of the eligible set, searching upward from (last_owner+1) mod NUM_RX.
- FSM has two states, IDLE and HOLD.
- IDLE:
  - pop_grant_fifo = 1 if the word is bad, or if the word is good and the eligible set is non-zero; else 0.
  - Bad word popped: discarded, count += 1 saturating at all-ones, parity_err = 1 next cycle, stay IDLE.
  - Good word popped: payload → data_out register, owner ← pick, timer ← 0, go HOLD.
- HOLD:
  - pop_grant_fifo = 0; no parity checking.
  - pop_valid_receiver = one-hot(owner).
  - Owner's pop_grant_receiver high: transfer, last_owner ← owner, go IDLE.
  - Otherwise timer += 1. When timer == HOLD_TIMEOUT-1 with no transfer (HOLD_TIMEOUT ≠ 0):
    - re-pick round-robin from owner+1 over eligible & ~one-hot(owner);
    - if that set is empty, keep owner;
    - timer ← 0; data_out unchanged.
- The owner deasserting req_receiver or rx_enable during HOLD does not revoke ownership; only the timeout re-assigns.
- Grants from non-owner receivers are ignored.
- pop_valid_receiver is zero in IDLE.
- Reset values:
  - state IDLE; owner 0; last_owner NUM_RX-1, so the first pick starts at receiver 0.
  - timer 0; data_out 0; parity_err 0; parity_err_count 0; pop_valid_receiver 0.
  - pop_grant_fifo is forced 0 while rst is high.
- Reset mid-HOLD discards the buffered word; no receiver transfer occurs on the reset edge.

## Timing
- pop_grant_fifo is combinational from state, data_in, req_receiver and rx_enable.
- All other outputs are registered.
- Good word accepted at edge k: pop_valid_receiver/data_out valid during cycle k+1.
- With the owner's grant in cycle k+1, transfer at edge k+1, IDLE in cycle k+2, next acceptance at edge k+2.
- Peak throughput: one good word per 2 cycles.
- Bad words drop at one per cycle while IDLE, even with no requesters.
- parity_err pulses in the cycle after the drop edge; the count updates on the same edge.
- Timeout: the owner sees valid for exactly HOLD_TIMEOUT cycles before re-assignment; the new owner is visible the next cycle.

## Test plan
- Reset, then DATA_WIDTH=8, EVEN_ODD=0, LSB, req=4'b0001, grant=4'b0001, data_in=9'h0A4 valid → pop_grant_fifo=1; next cycle pop_valid_receiver=4'b0001, data_out=8'h52, owner=0; IDLE after.
- data_in=9'h0A5 valid for 3 cycles, req=0 → pop_grant_fifo=1 each cycle, parity_err pulses 3 times, count=3, pop_valid_receiver stays 0.
- req=4'b1111, grants always 1, 8 good words → owners 0,1,2,3,0,1,2,3, one word per 2 cycles.
- rx_enable=4'b1011, req=4'b1111 → receiver 2 never owns; owner order 0,1,3,0.
- HOLD_TIMEOUT=4, req=4'b0011, receiver 0 owner with grant low → valid on receiver 0 for 4 cycles, then owner=1 with data_out unchanged; grant on receiver 1 transfers.
- ERR_CNT_WIDTH=2, 5 bad words → count 1,2,3,3,3; rst asserted during HOLD → pop_valid_receiver=0 next cycle, count=0, owner=0.

Source files
------------

// File: rtl/parity_pop_scheduler.sv
// parity_pop_scheduler: parity-checking FIFO pop controller that hands
// good words to NUM_RX receivers round-robin, re-assigning stalled owners.
module parity_pop_scheduler #(
  parameter int DATA_WIDTH        = 8,
  parameter int NUM_RX            = 4,
  parameter bit EVEN_ODD          = 1'b0,
  parameter bit SELECT_PARITY_BIT = 1'b0,
  parameter int HOLD_TIMEOUT      = 16,
  parameter int ERR_CNT_WIDTH     = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [DATA_WIDTH:0]        data_in,
  input  logic                       pop_valid_fifo,
  output logic                       pop_grant_fifo,
  input  logic [NUM_RX-1:0]          req_receiver,
  input  logic [NUM_RX-1:0]          rx_enable,
  output logic [NUM_RX-1:0]          pop_valid_receiver,
  input  logic [NUM_RX-1:0]          pop_grant_receiver,
  output logic [DATA_WIDTH-1:0]      data_out,
  output logic [$clog2(NUM_RX)-1:0]  owner,
  output logic                       parity_err,
  output logic [ERR_CNT_WIDTH-1:0]   parity_err_count
);

  localparam int OW = $clog2(NUM_RX);
  localparam int TW = (HOLD_TIMEOUT > 1) ? $clog2(HOLD_TIMEOUT) : 1;
  localparam logic [TW-1:0] T_LAST =
    TW'((HOLD_TIMEOUT > 0) ? HOLD_TIMEOUT - 1 : 0);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t                  state_q, state_d;
  logic [OW-1:0]           owner_d, last_q, last_d;
  logic [TW-1:0]           timer_q, timer_d;
  logic [DATA_WIDTH-1:0]   data_d;
  logic [NUM_RX-1:0]       pvr_d;
  logic                    perr_d;
  logic [ERR_CNT_WIDTH-1:0] cnt_d;

  logic                    par_bit;
  logic                    good;
  logic [DATA_WIDTH-1:0]   payload;
  logic [NUM_RX-1:0]       elig;
  logic [NUM_RX-1:0]       elig_re;
  logic [NUM_RX-1:0]       own_oh;
  logic [OW-1:0]           pick_new;
  logic [OW-1:0]           pick_re;
  logic                    fire;
  logic                    xfer;
  logic                    expire;

  // First set bit of m strictly after prev, wrapping back to prev last.
  function automatic logic [OW-1:0] rr_pick(
    input logic [NUM_RX-1:0] m,
    input logic [OW-1:0]     prev
  );
    logic [OW-1:0] r;
    logic          hit;
    int            idx;
    r   = prev;
    hit = 1'b0;
    for (int i = 1; i <= NUM_RX; i++) begin
      idx = (int'(prev) + i) % NUM_RX;
      if (!hit && m[idx]) begin
        r   = OW'(idx);
        hit = 1'b1;
      end
    end
    return r;
  endfunction

  assign par_bit  = SELECT_PARITY_BIT ? data_in[DATA_WIDTH] : data_in[0];
  assign good     = (par_bit == EVEN_ODD);
  assign payload  = SELECT_PARITY_BIT ? data_in[DATA_WIDTH-1:0]
                                      : data_in[DATA_WIDTH:1];
  assign elig     = req_receiver & rx_enable;
  assign own_oh   = NUM_RX'(1) << owner;
  assign elig_re  = elig & ~own_oh;
  assign pick_new = rr_pick(elig, last_q);
  assign pick_re  = rr_pick(elig_re, owner);

  assign pop_grant_fifo = !rst && (state_q == IDLE) && (!good || (|elig));
  assign fire   = pop_grant_fifo && pop_valid_fifo;
  assign xfer   = (state_q == HOLD) && (|(pop_grant_receiver & own_oh));
  assign expire = (state_q == HOLD) && !xfer && (HOLD_TIMEOUT != 0) &&
                  (timer_q == T_LAST);

  always_comb begin
    state_d = state_q;
    owner_d = owner;
    last_d  = last_q;
    timer_d = timer_q;
    data_d  = data_out;
    pvr_d   = pop_valid_receiver;
    perr_d  = 1'b0;
    cnt_d   = parity_err_count;
    unique case (state_q)
      IDLE: begin
        if (fire && !good) begin
          perr_d = 1'b1;
          if (parity_err_count != '1) cnt_d = parity_err_count + 1'b1;
        end else if (fire) begin
          data_d  = payload;
          owner_d = pick_new;
          timer_d = '0;
          pvr_d   = NUM_RX'(1) << pick_new;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (xfer) begin
          last_d  = owner;
          pvr_d   = '0;
          state_d = IDLE;
        end else if (expire) begin
          // No other eligible receiver: the current owner keeps the word.
          owner_d = (|elig_re) ? pick_re : owner;
          pvr_d   = (|elig_re) ? (NUM_RX'(1) << pick_re) : own_oh;
          timer_d = '0;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q            <= IDLE;
      owner              <= '0;
      last_q             <= OW'(NUM_RX - 1);
      timer_q            <= '0;
      data_out           <= '0;
      pop_valid_receiver <= '0;
      parity_err         <= 1'b0;
      parity_err_count   <= '0;
    end else begin
      state_q            <= state_d;
      owner              <= owner_d;
      last_q             <= last_d;
      timer_q            <= timer_d;
      data_out           <= data_d;
      pop_valid_receiver <= pvr_d;
      parity_err         <= perr_d;
      parity_err_count   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_parity_pop_scheduler.sv
// tb_parity_pop_scheduler: directed checks of parity drop, round-robin,
// hold timeout, counter saturation and mid-HOLD reset.
module tb_parity_pop_scheduler;

  logic       clk = 1'b0;
  logic       rst;
  logic [8:0] data_in;
  logic       pop_valid_fifo;
  logic       pop_grant_fifo;
  logic [3:0] req_receiver;
  logic [3:0] rx_enable;
  logic [3:0] pop_valid_receiver;
  logic [3:0] pop_grant_receiver;
  logic [7:0] data_out;
  logic [1:0] owner;
  logic       parity_err;
  logic [1:0] parity_err_count;

  int n_assert = 0;
  int n_fail   = 0;

  logic [1:0] own4 [4] = '{2'd0, 2'd1, 2'd3, 2'd0};

  always #5 clk = ~clk;

  parity_pop_scheduler #(
    .DATA_WIDTH(8), .NUM_RX(4), .EVEN_ODD(1'b0),
    .SELECT_PARITY_BIT(1'b0), .HOLD_TIMEOUT(4), .ERR_CNT_WIDTH(2)
  ) dut (
    .clk(clk), .rst(rst),
    .data_in(data_in),
    .pop_valid_fifo(pop_valid_fifo),
    .pop_grant_fifo(pop_grant_fifo),
    .req_receiver(req_receiver),
    .rx_enable(rx_enable),
    .pop_valid_receiver(pop_valid_receiver),
    .pop_grant_receiver(pop_grant_receiver),
    .data_out(data_out),
    .owner(owner),
    .parity_err(parity_err),
    .parity_err_count(parity_err_count)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic serve(input logic [7:0] pl, input logic [1:0] exp_own);
    data_in        = {pl, 1'b0};
    pop_valid_fifo = 1'b1;
    #1 chk("rr_accept", pop_grant_fifo, 1);
    tick();
    chk("rr_owner", owner, exp_own);
    chk("rr_valid", pop_valid_receiver, 4'b0001 << exp_own);
    chk("rr_data", data_out, pl);
    #1 chk("rr_hold_nopop", pop_grant_fifo, 0);
    tick();
  endtask

  initial begin
    rst                = 1'b1;
    data_in            = 9'h0A5;
    pop_valid_fifo     = 1'b1;
    req_receiver       = 4'hF;
    rx_enable          = 4'hF;
    pop_grant_receiver = 4'h0;
    tick();
    tick();
    chk("rst_pop_grant", pop_grant_fifo, 0);
    chk("rst_pvr", pop_valid_receiver, 0);
    chk("rst_owner", owner, 0);
    chk("rst_data", data_out, 0);
    chk("rst_perr", parity_err, 0);
    chk("rst_cnt", parity_err_count, 0);
    pop_valid_fifo = 1'b0;
    rst = 1'b0;
    tick();

    // single good word to receiver 0
    req_receiver       = 4'b0001;
    pop_grant_receiver = 4'b0001;
    data_in            = 9'h0A4;
    pop_valid_fifo     = 1'b1;
    #1 chk("t1_grant", pop_grant_fifo, 1);
    tick();
    pop_valid_fifo = 1'b0;
    chk("t1_pvr", pop_valid_receiver, 4'b0001);
    chk("t1_data", data_out, 8'h52);
    chk("t1_owner", owner, 0);
    tick();
    chk("t1_idle_pvr", pop_valid_receiver, 0);
    req_receiver   = 4'b0000;
    pop_valid_fifo = 1'b1;
    #1 chk("t1_no_req_grant", pop_grant_fifo, 0);

    // bad words drop with no requesters
    data_in = 9'h0A5;
    for (int i = 0; i < 3; i++) begin
      #1 chk("t2_grant", pop_grant_fifo, 1);
      tick();
      chk("t2_perr", parity_err, 1);
      chk("t2_cnt", parity_err_count, i + 1);
      chk("t2_pvr", pop_valid_receiver, 0);
    end
    pop_valid_fifo = 1'b0;
    tick();
    chk("t2_perr_end", parity_err, 0);
    chk("t2_cnt_end", parity_err_count, 3);

    // round-robin over all four receivers
    do_reset();
    req_receiver       = 4'hF;
    pop_grant_receiver = 4'hF;
    for (int i = 0; i < 8; i++) serve(8'(8'h10 + i), 2'(i % 4));
    pop_valid_fifo = 1'b0;

    // receiver 2 disabled
    do_reset();
    rx_enable = 4'b1011;
    for (int i = 0; i < 4; i++) serve(8'(8'h60 + 3 * i), own4[i]);
    pop_valid_fifo = 1'b0;

    // hold timeout re-assigns 0 -> 1, non-owner grant ignored meanwhile
    do_reset();
    rx_enable          = 4'hF;
    req_receiver       = 4'b0011;
    pop_grant_receiver = 4'b0000;
    data_in            = 9'h078;
    pop_valid_fifo     = 1'b1;
    #1 chk("t5_grant", pop_grant_fifo, 1);
    tick();
    pop_valid_fifo     = 1'b0;
    pop_grant_receiver = 4'b0010;
    for (int c = 0; c < 4; c++) begin
      chk("t5_hold_pvr", pop_valid_receiver, 4'b0001);
      chk("t5_hold_owner", owner, 0);
      tick();
    end
    chk("t5_new_owner", owner, 1);
    chk("t5_new_pvr", pop_valid_receiver, 4'b0010);
    chk("t5_data_kept", data_out, 8'h3C);
    tick();
    chk("t5_xfer_pvr", pop_valid_receiver, 0);

    // error counter saturation, then reset mid-HOLD
    do_reset();
    req_receiver       = 4'b0000;
    pop_grant_receiver = 4'b0000;
    data_in            = 9'h0A5;
    pop_valid_fifo     = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t6_cnt", parity_err_count, (i < 3) ? i + 1 : 3);
    end
    req_receiver = 4'b0010;
    data_in      = 9'h0A4;
    tick();
    pop_valid_fifo = 1'b0;
    chk("t6_hold_owner", owner, 1);
    chk("t6_hold_pvr", pop_valid_receiver, 4'b0010);
    pop_grant_receiver = 4'b0010;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t6_rst_pvr", pop_valid_receiver, 0);
    chk("t6_rst_cnt", parity_err_count, 0);
    chk("t6_rst_owner", owner, 0);
    chk("t6_rst_data", data_out, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
